// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
//   Chooses the 10-bit word handed to a parallel-to-serial converter at each
//   serializer word boundary. After reset (or on a resync request) it sends
//   SYNC_WORDS comma words. It then enters ACTIVE, where it serves two
//   requesters round-robin and sends IDLE when neither has a word pending.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   enb             global enable; low freezes state and clears acks
//   wordTick        one-clk word-boundary pulse (update event when enb=1)
//   resync          pulse requesting a new synchronization phase
//   reqA/dataA      requester A pending flag and word
//   reqB/dataB      requester B pending flag and word
//   entradas        registered word for the serializer
//   ackA/ackB       one-clk consume pulses, the cycle after a grant
//   syncDone        high while ACTIVE
//   dataCnt         data words issued since reset (wraps)
module serial_tx_scheduler #(
    parameter int unsigned SYNC_WORDS = 4,
    parameter logic [9:0]  COMMA      = 10'h0FA,
    parameter logic [9:0]  IDLE       = 10'h305
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        wordTick,
    input  logic        resync,
    input  logic        reqA,
    input  logic [9:0]  dataA,
    input  logic        reqB,
    input  logic [9:0]  dataB,
    output logic [9:0]  entradas,
    output logic        ackA,
    output logic        ackB,
    output logic        syncDone,
    output logic [15:0] dataCnt
);

    typedef enum logic {StSync, StActive} state_e;

    localparam logic [4:0] SyncWordsW = 5'(SYNC_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic        resync_q, resync_d;
    logic        last_grant_q, last_grant_d;  // 0 = A, 1 = B
    logic [9:0]  entradas_q, entradas_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic [15:0] data_cnt_q, data_cnt_d;

    logic       update;
    logic       grant_a, grant_b;
    logic [4:0] sync_inc;

    assign update   = enb & wordTick;
    // When both request, serve the one not granted last time.
    assign grant_a  = reqA & (~reqB | last_grant_q);
    assign grant_b  = reqB & (~reqA | ~last_grant_q);
    assign sync_inc = {1'b0, sync_cnt_q} + 5'd1;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        last_grant_d = last_grant_q;
        entradas_d   = entradas_q;
        data_cnt_d   = data_cnt_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        resync_d     = resync_q | (enb & resync);

        if (update) begin
            // A resync on the tick itself counts as if it had been latched.
            if (resync_q || resync) begin
                entradas_d = COMMA;
                resync_d   = 1'b0;
                sync_cnt_d = 4'd1;
                state_d    = StSync;
            end else begin
                unique case (state_q)
                    StSync: begin
                        entradas_d = COMMA;
                        // >= keeps SYNC_WORDS=1 from sticking after a resync preload of 1.
                        if (sync_inc >= SyncWordsW) begin
                            sync_cnt_d = 4'd0;
                            state_d    = StActive;
                        end else begin
                            sync_cnt_d = sync_inc[3:0];
                        end
                    end
                    StActive: begin
                        if (grant_a) begin
                            entradas_d   = dataA;
                            ack_a_d      = 1'b1;
                            last_grant_d = 1'b0;
                            data_cnt_d   = data_cnt_q + 16'd1;
                        end else if (grant_b) begin
                            entradas_d   = dataB;
                            ack_b_d      = 1'b1;
                            last_grant_d = 1'b1;
                            data_cnt_d   = data_cnt_q + 16'd1;
                        end else begin
                            entradas_d = IDLE;
                        end
                    end
                    default: state_d = StSync;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSync;
            sync_cnt_q   <= 4'd0;
            resync_q     <= 1'b0;
            last_grant_q <= 1'b1;
            entradas_q   <= COMMA;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            data_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            resync_q     <= resync_d;
            last_grant_q <= last_grant_d;
            entradas_q   <= entradas_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            data_cnt_q   <= data_cnt_d;
        end
    end

    assign entradas = entradas_q;
    assign ackA     = ack_a_q;
    assign ackB     = ack_b_q;
    assign syncDone = (state_q == StActive);
    assign dataCnt  = data_cnt_q;

endmodule
